// File: rtl/lp805x_fs_defs.sv
// Frequency-scaling definitions shared by lp805x_fsgate, lp805x_schedfs and the power-control SFR.
package lp805x_fs_defs;

    localparam int unsigned FS_DW        = 8;
    localparam logic [7:0]  FS_STOP_CODE = 8'hFF;

    typedef enum logic [1:0] {
        FS_RUN  = 2'd0,
        FS_PEND = 2'd1,
        FS_STOP = 2'd2
    } fs_state_e;

endpackage

// File: rtl/lp805x_fsgate_cnt.sv
// Loadable down-counter with zero flag; the enable period timer of lp805x_fsgate.
module lp805x_fsgate_cnt
    import lp805x_fs_defs::*;
#(
    parameter int unsigned DW = FS_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    output logic [DW-1:0] cnt,
    output logic          zero
);

    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;

    always_comb begin
        cnt_d = load ? load_val : cnt_q - DW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/lp805x_fsgate.sv
// Clock-enable gate: turns the scheduler divide code into a 1-of-(index+1) enable pulse train.
// Optional macro LP805X_FSGATE_WAKE_EN adds the wake input (forced full-speed exit).
module lp805x_fsgate
    import lp805x_fs_defs::*;
#(
    parameter int unsigned   DW        = FS_DW,
    parameter logic [DW-1:0] STOP_CODE = DW'(FS_STOP_CODE)
) (
    input  logic          clki,
    input  logic          rst,
    input  logic [DW-1:0] index,
`ifdef LP805X_FSGATE_WAKE_EN
    input  logic          wake,
`endif
    output logic          clk_en,
    output logic [DW-1:0] cur_index,
    output logic          fs_ack,
    output logic          stopped
);

    fs_state_e     state_q, state_d;
    logic [DW-1:0] idx_q, idx_d;
    logic [DW-1:0] cur_q, cur_d;
    logic          clk_en_q, clk_en_d;
    logic          fs_ack_q, fs_ack_d;
    logic          cnt_load;
    logic [DW-1:0] cnt_val;
    logic [DW-1:0] cnt;
    logic          cnt_zero;

    lp805x_fsgate_cnt #(.DW(DW)) u_cnt (
        .clk      (clki),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_comb begin
        idx_d    = index;
        cur_d    = cur_q;
        state_d  = state_q;
        clk_en_d = 1'b0;
        fs_ack_d = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = cur_q;
        unique case (state_q)
            FS_RUN: begin
                if (cnt_zero) begin
                    clk_en_d = 1'b1;
                    cnt_load = 1'b1;
                end
                if (idx_q != cur_q) state_d = FS_PEND;
            end
            FS_PEND: begin
                if (idx_q == cur_q) begin
                    state_d = FS_RUN;
                    if (cnt_zero) begin
                        clk_en_d = 1'b1;
                        cnt_load = 1'b1;
                    end
                end else if (cnt_zero) begin
                    // Boundary: the old period's closing pulse and the new ratio share this edge.
                    cur_d    = idx_q;
                    fs_ack_d = 1'b1;
                    cnt_load = 1'b1;
                    if (idx_q == STOP_CODE) begin
                        cnt_val = '0;
                        state_d = FS_STOP;
                    end else begin
                        cnt_val  = idx_q;
                        clk_en_d = 1'b1;
                        state_d  = FS_RUN;
                    end
                end
            end
            FS_STOP: begin
                cnt_load = 1'b1;
                cnt_val  = '0;
                if (idx_q != STOP_CODE) begin
                    cur_d    = idx_q;
                    fs_ack_d = 1'b1;
                    state_d  = FS_RUN;
                end
            end
            default: begin
                cnt_load = 1'b1;
                cnt_val  = '0;
                state_d  = FS_RUN;
            end
        endcase
`ifdef LP805X_FSGATE_WAKE_EN
        if (wake) begin
            cur_d    = '0;
            cnt_load = 1'b1;
            cnt_val  = '0;
            state_d  = FS_RUN;
            fs_ack_d = 1'b1;
            clk_en_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            state_q  <= FS_RUN;
            idx_q    <= '0;
            cur_q    <= '0;
            clk_en_q <= 1'b0;
            fs_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cur_q    <= cur_d;
            clk_en_q <= clk_en_d;
            fs_ack_q <= fs_ack_d;
        end
    end

    assign clk_en    = clk_en_q;
    assign cur_index = cur_q;
    assign fs_ack    = fs_ack_q;
    assign stopped   = (state_q == FS_STOP);

endmodule

// File: tb/tb_lp805x_fsgate.sv
// Directed self-checking bench for lp805x_fsgate; expected values are hand-derived per cycle.
module tb_lp805x_fsgate;

    logic       clki = 1'b0;
    logic       rst;
    logic [7:0] index;
    logic       wake;
    logic       clk_en;
    logic [7:0] cur_index;
    logic       fs_ack;
    logic       stopped;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    lp805x_fsgate dut (
        .clki      (clki),
        .rst       (rst),
        .index     (index),
`ifdef LP805X_FSGATE_WAKE_EN
        .wake      (wake),
`endif
        .clk_en    (clk_en),
        .cur_index (cur_index),
        .fs_ack    (fs_ack),
        .stopped   (stopped)
    );

    always #5 clki = ~clki;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic en, input logic ack,
                           input logic [7:0] cur, input logic stp);
        chk({tag, "_clk_en"},    32'(clk_en),    32'(en));
        chk({tag, "_fs_ack"},    32'(fs_ack),    32'(ack));
        chk({tag, "_cur_index"}, 32'(cur_index), 32'(cur));
        chk({tag, "_stopped"},   32'(stopped),   32'(stp));
    endtask

    // Advance one edge, then check outputs 1 time unit later.
    task automatic step(input string tag, input logic en, input logic ack,
                        input logic [7:0] cur, input logic stp);
        @(posedge clki);
        #1;
        chk_out(tag, en, ack, cur, stp);
    endtask

    initial begin
        rst   = 1'b1;
        index = 8'd0;
        wake  = 1'b0;
        repeat (2) @(posedge clki);
        #1;
        chk_out("reset", 1'b0, 1'b0, 8'd0, 1'b0);

        // index=0: enable every cycle from the first edge after release
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step("div1", 1'b1, 1'b0, 8'd0, 1'b0);

        // index=3: sample, pend, adopt at boundary, then period 4
        index = 8'd3;
        step("to3_t1", 1'b1, 1'b0, 8'd0, 1'b0);
        step("to3_t2", 1'b1, 1'b0, 8'd0, 1'b0);
        step("to3_ack", 1'b1, 1'b1, 8'd3, 1'b0);
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 3; i++) step("div4_lo", 1'b0, 1'b0, 8'd3, 1'b0);
            step("div4_hi", 1'b1, 1'b0, 8'd3, 1'b0);
        end
        step("div4_lo_cnt2", 1'b0, 1'b0, 8'd3, 1'b0);

        // 3->7 with cnt=2: old period completes before the new ratio
        index = 8'd7;
        step("to7_t1", 1'b0, 1'b0, 8'd3, 1'b0);
        step("to7_t2", 1'b0, 1'b0, 8'd3, 1'b0);
        step("to7_ack", 1'b1, 1'b1, 8'd7, 1'b0);
        for (int i = 0; i < 7; i++) step("div8_lo", 1'b0, 1'b0, 8'd7, 1'b0);
        step("div8_hi", 1'b1, 1'b0, 8'd7, 1'b0);

        // STOP_CODE: adopted at the boundary with no pulse, then held
        index = 8'hFF;
        for (int i = 0; i < 7; i++) step("tostop_lo", 1'b0, 1'b0, 8'd7, 1'b0);
        step("tostop_ack", 1'b0, 1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 20; i++) step("stop_hold", 1'b0, 1'b0, 8'hFF, 1'b1);

        // exit STOP with index=1: ack, then pulses every 2 cycles
        index = 8'd1;
        step("exit_t1", 1'b0, 1'b0, 8'hFF, 1'b1);
        step("exit_ack", 1'b0, 1'b1, 8'd1, 1'b0);
        step("div2_hi0", 1'b1, 1'b0, 8'd1, 1'b0);
        step("div2_lo0", 1'b0, 1'b0, 8'd1, 1'b0);
        step("div2_hi1", 1'b1, 1'b0, 8'd1, 1'b0);
        step("div2_lo1", 1'b0, 1'b0, 8'd1, 1'b0);
        step("div2_hi2", 1'b1, 1'b0, 8'd1, 1'b0);

        // set up cur_index=5
        index = 8'd5;
        step("to5_t1", 1'b0, 1'b0, 8'd1, 1'b0);
        step("to5_t2", 1'b1, 1'b0, 8'd1, 1'b0);
        step("to5_t3", 1'b0, 1'b0, 8'd1, 1'b0);
        step("to5_ack", 1'b1, 1'b1, 8'd5, 1'b0);
        for (int i = 0; i < 5; i++) step("div6_lo", 1'b0, 1'b0, 8'd5, 1'b0);
        step("div6_hi", 1'b1, 1'b0, 8'd5, 1'b0);

        // 5->2->5 inside the pending window: no ack, period stays 6
        index = 8'd2;
        step("bounce_t1", 1'b0, 1'b0, 8'd5, 1'b0);
        index = 8'd5;
        for (int i = 0; i < 4; i++) step("bounce_lo", 1'b0, 1'b0, 8'd5, 1'b0);
        step("bounce_hi", 1'b1, 1'b0, 8'd5, 1'b0);

        // asynchronous reset while a change to 9 is pending
        index = 8'd9;
        step("pend9_t1", 1'b0, 1'b0, 8'd5, 1'b0);
        step("pend9_t2", 1'b0, 1'b0, 8'd5, 1'b0);
        rst = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 1'b0, 8'd0, 1'b0);
        @(posedge clki);
        #1;
        index = 8'd0;
        rst   = 1'b0;
        step("post_rst", 1'b1, 1'b0, 8'd0, 1'b0);

`ifdef LP805X_FSGATE_WAKE_EN
        // wake from STOP: immediate full speed on the next edge
        index = 8'hFF;
        step("wstop_t1", 1'b1, 1'b0, 8'd0, 1'b0);
        step("wstop_t2", 1'b1, 1'b0, 8'd0, 1'b0);
        step("wstop_ack", 1'b0, 1'b1, 8'hFF, 1'b1);
        step("wstop_hold", 1'b0, 1'b0, 8'hFF, 1'b1);
        wake = 1'b1;
        step("wake_ack", 1'b1, 1'b1, 8'd0, 1'b0);
        wake = 1'b0;
        step("wake_after", 1'b1, 1'b0, 8'd0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
